mem_write_monitor: RTL
======================

// Module: mem_write_monitor
// PURPOSE
//  Synthesizable checker on the processor's data-memory write port (MemWrite/DataAdr/WriteData out of top).
//  Classifies every store against a pass address/data and an allowed scratch address.
//  Bounds the run with a cycle limit and latches a sticky verdict, usable on FPGA LEDs or by a bench.
//  Sits directly downstream of top, in parallel with data memory.
// PARAMETERS
//  PASS_ADR     32'd100  store address whose data decides pass/fail
//  PASS_DATA    32'd7    data required at PASS_ADR for a pass
//  SCRATCH_ADR  32'd96   store address tolerated without verdict
//  CYCLE_LIMIT  40       cycles in RUN before timeout (>=2)
//  CNT_W        16       cycle_count width; CYCLE_LIMIT must be < 2**CNT_W
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high reset
//  MemWrite     in   1   store strobe from top, one cycle per store
//  DataAdr      in   32  store address
//  WriteData    in   32  store data
//  done         out  1   verdict reached (pass|fail|timeout)
//  pass         out  1   PASS_DATA stored at PASS_ADR
//  fail         out  1   illegal store seen
//  timeout      out  1   CYCLE_LIMIT reached with no verdict
//  write_count  out  8   stores accepted in RUN, saturates at 255
//  cycle_count  out  CNT_W  cycles spent in RUN
//  fail_adr     out  32  DataAdr of the failing store
//  fail_data    out  32  WriteData of the failing store
//  hist_idx     in   3   history read index, 0 = newest (HIST feature)
//  hist_adr     out  32  address of history entry hist_idx
//  hist_data    out  32  data of history entry hist_idx
//  hist_cnt     out  4   valid history entries, 0..8
// BEHAVIOUR
//  - FSM states RUN, PASS, FAIL, TIMEOUT; reset -> RUN; PASS/FAIL/TIMEOUT sticky until reset.
//  - Reset values: all outputs 0; cycle_count 0; history pointer 0; hist_cnt 0.
//  - All inputs sampled on rising clk; flags are registered, asserted the cycle after the deciding edge.
//  - In RUN, per edge, priority order:
//      1 MemWrite & DataAdr==PASS_ADR & WriteData==PASS_DATA -> PASS
//      2 MemWrite & DataAdr==PASS_ADR & data mismatch         -> FAIL
//      3 MemWrite & DataAdr==SCRATCH_ADR                      -> stay RUN
//      4 MemWrite & any other address                         -> FAIL
//      5 no decisive store & cycle_count==CYCLE_LIMIT-1       -> TIMEOUT
//  - A decisive store wins over timeout on the same edge.
//  - On entering FAIL, latch fail_adr/fail_data from that edge; both stay 0 for PASS and TIMEOUT.
//  - write_count +1 on every MemWrite in RUN, decisive store included; saturates at 255.
//  - cycle_count +1 on every edge in RUN; frozen in terminal states; equals CYCLE_LIMIT on timeout.
//  - done = pass|fail|timeout; at most one of pass/fail/timeout is ever 1.
//  - MemWrite in terminal states is ignored: no counts, no history, no verdict change.
//  - X on DataAdr/WriteData with MemWrite=0 has no effect.
//  - reset asserted mid-run clears everything asynchronously; first edge after release is RUN cycle 0.
// CONFIGURATION
//  MEM_MONITOR_HIST_EN defined:
//   - 8-entry circular buffer of {DataAdr,WriteData}, written on every MemWrite in RUN.
//   - Write pointer wraps 7->0, overwriting the oldest entry; hist_cnt saturates at 8.
//   - Combinational read: entry (wptr-1-hist_idx) mod 8.
//   - hist_adr/hist_data are 0 when hist_idx >= hist_cnt.
//  MEM_MONITOR_HIST_EN undefined:
//   - No buffer storage; hist_adr, hist_data, hist_cnt tied to 0; hist_idx ignored.
// TESTING
//  1 Stores (96,3),(96,5),(100,7) -> pass=1 one cycle after 3rd store; write_count=3; fail=0; done=1.
//  2 Store (100,6) -> fail=1; fail_adr=100; fail_data=6. Later store (100,7) -> no change, write_count stays 1.
//  3 Store (104,7) on cycle 10 -> fail=1; fail_adr=104; cycle_count frozen at 11.
//  4 No stores for 40 cycles -> timeout=1 after 40th edge; cycle_count=40.
//    Store (100,7) exactly on edge 40 instead -> pass=1, timeout=0.
//  5 Reset pulsed mid-cycle after 5 scratch stores -> all outputs 0 immediately;
//    rerun of test 1 passes again with write_count=3.
//  6 HIST_EN, CYCLE_LIMIT=64: 10 stores (96,1..10) ->
//    hist_cnt=8; idx0=(96,10); idx7=(96,3); idx0 again after wrap correct.

Source files
------------

// File: rtl/mem_write_monitor.sv
// mem_write_monitor
//   Watches the data-memory write port of the processor and reaches a sticky
//   verdict: pass when PASS_DATA is stored at PASS_ADR, fail on any other store
//   outside SCRATCH_ADR, timeout when CYCLE_LIMIT cycles elapse with no verdict.
//   Intended for FPGA status LEDs or for a simulation bench.
//
// Parameters
//   PASS_ADR     store address whose data decides pass/fail
//   PASS_DATA    data required at PASS_ADR for a pass
//   SCRATCH_ADR  store address tolerated without a verdict
//   CYCLE_LIMIT  cycles in RUN before timeout (>= 2)
//   CNT_W        cycle counter width, CYCLE_LIMIT < 2**CNT_W
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   MemWrite            store strobe, one cycle per store
//   DataAdr, WriteData  store address / data
//   done                pass | fail | timeout
//   pass, fail, timeout one-hot sticky verdict flags
//   write_count         stores seen in RUN, saturating at 255
//   cycle_count         cycles spent in RUN
//   fail_adr, fail_data the store that caused fail
//   hist_idx            history read index, 0 = newest
//   hist_adr, hist_data history entry selected by hist_idx
//   hist_cnt            number of valid history entries, 0..8
//
// Build option
//   MEM_MONITOR_HIST_EN  when defined, keeps an 8-entry store history;
//                        otherwise the hist_* outputs are tied to 0.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RUN   | counting cycles, classifying every store
// S_PASS  | PASS_DATA written to PASS_ADR; frozen until reset
// S_FAIL  | illegal store seen, fail_adr/fail_data hold it; frozen
// S_TOUT  | CYCLE_LIMIT cycles elapsed with no verdict; frozen

module mem_write_monitor #(
    parameter logic [31:0] PASS_ADR    = 32'd100,
    parameter logic [31:0] PASS_DATA   = 32'd7,
    parameter logic [31:0] SCRATCH_ADR = 32'd96,
    parameter int          CYCLE_LIMIT = 40,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [7:0]       write_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      fail_adr,
    output logic [31:0]      fail_data,
    input  logic [2:0]       hist_idx,
    output logic [31:0]      hist_adr,
    output logic [31:0]      hist_data,
    output logic [3:0]       hist_cnt
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PASS = 2'd1,
        S_FAIL = 2'd2,
        S_TOUT = 2'd3
    } state_t;

    // Timeout down-counter starts at CYCLE_LIMIT-1 and hits zero on the edge
    // where cycle_count == CYCLE_LIMIT-1.
    localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(CYCLE_LIMIT - 1);

    state_t           state;
    logic [CNT_W-1:0] tmr;

    logic adr_is_pass;
    logic adr_is_scr;
    logic data_ok;
    logic pass_hit;
    logic fail_hit;
    logic run_store;

    assign adr_is_pass = (DataAdr == PASS_ADR);
    assign adr_is_scr  = (DataAdr == SCRATCH_ADR);
    assign data_ok     = (WriteData == PASS_DATA);

    // MemWrite gates everything so a floating bus while idle cannot decide.
    assign pass_hit  = MemWrite & adr_is_pass & data_ok;
    assign fail_hit  = MemWrite & (adr_is_pass ? ~data_ok : ~adr_is_scr);
    assign run_store = MemWrite & (state == S_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            write_count <= 8'd0;
            cycle_count <= '0;
            fail_adr    <= 32'd0;
            fail_data   <= 32'd0;
            tmr         <= TMR_LOAD;
        end else if (state == S_RUN) begin
            cycle_count <= cycle_count + 1'b1;
            if (tmr != '0) begin
                tmr <= tmr - 1'b1;
            end
            if (MemWrite && (write_count != 8'hFF)) begin
                write_count <= write_count + 8'd1;
            end
            // A decisive store on the final cycle beats the timeout.
            if (pass_hit) begin
                state <= S_PASS;
                pass  <= 1'b1;
                done  <= 1'b1;
            end else if (fail_hit) begin
                state     <= S_FAIL;
                fail      <= 1'b1;
                done      <= 1'b1;
                fail_adr  <= DataAdr;
                fail_data <= WriteData;
            end else if (tmr == '0) begin
                state   <= S_TOUT;
                timeout <= 1'b1;
                done    <= 1'b1;
            end
        end
    end

`ifdef MEM_MONITOR_HIST_EN
    logic [31:0] hbuf_adr  [8];
    logic [31:0] hbuf_data [8];
    logic [2:0]  wptr;
    logic [3:0]  hcnt;
    logic [2:0]  rptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= 3'd0;
            hcnt <= 4'd0;
        end else if (run_store) begin
            wptr <= wptr + 3'd1;
            if (hcnt != 4'd8) begin
                hcnt <= hcnt + 4'd1;
            end
        end
    end

    // Storage needs no reset: entries are only visible below hist_cnt.
    always_ff @(posedge clk) begin
        if (run_store) begin
            hbuf_adr[wptr]  <= DataAdr;
            hbuf_data[wptr] <= WriteData;
        end
    end

    // Newest entry sits just behind the write pointer; 3-bit wrap gives mod 8.
    assign rptr      = wptr - 3'd1 - hist_idx;
    assign hist_adr  = ({1'b0, hist_idx} < hcnt) ? hbuf_adr[rptr]  : 32'd0;
    assign hist_data = ({1'b0, hist_idx} < hcnt) ? hbuf_data[rptr] : 32'd0;
    assign hist_cnt  = hcnt;
`else
    logic unused_hist;
    assign unused_hist = ^{hist_idx, run_store};
    assign hist_adr    = 32'd0;
    assign hist_data   = 32'd0;
    assign hist_cnt    = 4'd0;
`endif

endmodule
